// File: rtl/wb_tag_arbiter_rr.sv
// wb_tag_arbiter_rr
//   N-initiator to 1-target tagged Wishbone arbiter. A grant is held for a
//   whole bus cycle (CYC), so multi-beat cycles are never interleaved and each
//   downstream bridge crossing belongs to exactly one initiator.
//   Default build: round-robin arbitration starting after the last owner.
//   With WB_TAG_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins.
// Ports
//   i_clock, reset        clock, asynchronous active-high reset
//   m_* (in)              packed initiator requests, initiator k in slice k
//   m_ack (out)           per-initiator acknowledge
//   m_dat_r, m_tgd_r      read data / tag broadcast to all initiators
//   t_* (out)             request muxed from the granted initiator
//   t_ack, t_dat_r, t_tgd_r (in)  target response
module wb_tag_arbiter_rr #(
   parameter int unsigned N_INIT    = 2,
   parameter int unsigned ADR_WIDTH = 32,
   parameter int unsigned DAT_WIDTH = 32,
   parameter int unsigned TGA_WIDTH = 4,
   parameter int unsigned TGD_WIDTH = 4,
   parameter int unsigned TGC_WIDTH = 4
) (
   input  logic                              i_clock,
   input  logic                              reset,
   input  logic [N_INIT*ADR_WIDTH-1:0]       m_adr,
   input  logic [N_INIT*DAT_WIDTH-1:0]       m_dat_w,
   input  logic [N_INIT*TGD_WIDTH-1:0]       m_tgd_w,
   input  logic [N_INIT*TGA_WIDTH-1:0]       m_tga,
   input  logic [N_INIT*TGC_WIDTH-1:0]       m_tgc,
   input  logic [N_INIT*(DAT_WIDTH/8)-1:0]   m_sel,
   input  logic [N_INIT-1:0]                 m_we,
   input  logic [N_INIT-1:0]                 m_cyc,
   input  logic [N_INIT-1:0]                 m_stb,
   output logic [N_INIT-1:0]                 m_ack,
   output logic [DAT_WIDTH-1:0]              m_dat_r,
   output logic [TGD_WIDTH-1:0]              m_tgd_r,
   output logic [ADR_WIDTH-1:0]              t_adr,
   output logic [DAT_WIDTH-1:0]              t_dat_w,
   output logic [TGD_WIDTH-1:0]              t_tgd_w,
   output logic [TGA_WIDTH-1:0]              t_tga,
   output logic [TGC_WIDTH-1:0]              t_tgc,
   output logic [(DAT_WIDTH/8)-1:0]          t_sel,
   output logic                              t_we,
   output logic                              t_cyc,
   output logic                              t_stb,
   input  logic                              t_ack,
   input  logic [DAT_WIDTH-1:0]              t_dat_r,
   input  logic [TGD_WIDTH-1:0]              t_tgd_r
);

   localparam int unsigned SEL_WIDTH = DAT_WIDTH / 8;
   localparam int unsigned GW        = (N_INIT > 1) ? $clog2(N_INIT) : 1;
   localparam int unsigned CW        = GW + 1;

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t              state_q, state_d;
   logic [GW-1:0]       grant_q, grant_d;
   logic [GW-1:0]       pick;
   logic [N_INIT-1:0]   req;
   logic                cyc_g;
   logic                stb_g;
`ifndef WB_TAG_ARB_FIXED_PRIO_EN
   logic [GW-1:0]       last_q, last_d;
   logic [CW-1:0]       cand;
   logic                found;
`endif

   assign req = m_cyc & m_stb;

   // Arbitration winner among current requests
`ifdef WB_TAG_ARB_FIXED_PRIO_EN
   always_comb begin
      pick = '0;
      for (int k = N_INIT - 1; k >= 0; k--) begin
         if (req[k]) pick = GW'(k);
      end
   end
`else
   // Search last+1, last+2, ... with wrap; the sum is one bit wider so a
   // single conditional subtract keeps the candidate below N_INIT.
   always_comb begin
      pick  = '0;
      found = 1'b0;
      cand  = '0;
      for (int i = 1; i <= N_INIT; i++) begin
         cand = CW'(last_q) + CW'(i);
         if (cand >= CW'(N_INIT)) cand = cand - CW'(N_INIT);
         for (int k = 0; k < N_INIT; k++) begin
            if (!found && req[k] && (cand == CW'(k))) begin
               found = 1'b1;
               pick  = GW'(k);
            end
         end
      end
   end
`endif

   // Request mux from the granted slice
   always_comb begin
      t_adr   = '0;
      t_dat_w = '0;
      t_tgd_w = '0;
      t_tga   = '0;
      t_tgc   = '0;
      t_sel   = '0;
      t_we    = 1'b0;
      cyc_g   = 1'b0;
      stb_g   = 1'b0;
      for (int k = 0; k < N_INIT; k++) begin
         if (grant_q == GW'(k)) begin
            t_adr   = m_adr  [k*ADR_WIDTH +: ADR_WIDTH];
            t_dat_w = m_dat_w[k*DAT_WIDTH +: DAT_WIDTH];
            t_tgd_w = m_tgd_w[k*TGD_WIDTH +: TGD_WIDTH];
            t_tga   = m_tga  [k*TGA_WIDTH +: TGA_WIDTH];
            t_tgc   = m_tgc  [k*TGC_WIDTH +: TGC_WIDTH];
            t_sel   = m_sel  [k*SEL_WIDTH +: SEL_WIDTH];
            t_we    = m_we[k];
            cyc_g   = m_cyc[k];
            stb_g   = m_stb[k];
         end
      end
   end

   assign m_dat_r = t_dat_r;
   assign m_tgd_r = t_tgd_r;

   // Next state and bus-side outputs
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
`ifndef WB_TAG_ARB_FIXED_PRIO_EN
      last_d  = last_q;
`endif
      t_cyc   = 1'b0;
      t_stb   = 1'b0;
      m_ack   = '0;
      case (state_q)
         IDLE: begin
            if (|req) begin
               grant_d = pick;
               state_d = BUSY;
            end
         end
         BUSY: begin
            t_cyc = cyc_g;
            t_stb = cyc_g & stb_g;
            for (int k = 0; k < N_INIT; k++) begin
               if (grant_q == GW'(k)) m_ack[k] = t_ack;
            end
            // Owner ended its cycle: release now, re-arbitrate next cycle
            if (!cyc_g) begin
               state_d = IDLE;
`ifndef WB_TAG_ARB_FIXED_PRIO_EN
               last_d  = grant_q;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers; last resets to N_INIT-1 so initiator 0 wins first
   always_ff @(posedge i_clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         grant_q <= '0;
`ifndef WB_TAG_ARB_FIXED_PRIO_EN
         last_q  <= GW'(N_INIT - 1);
`endif
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
`ifndef WB_TAG_ARB_FIXED_PRIO_EN
         last_q  <= last_d;
`endif
      end
   end

endmodule

// File: tb/tb_wb_tag_arbiter_rr.sv
// tb_wb_tag_arbiter_rr
//   Bench for wb_tag_arbiter_rr with four initiators. Initiator models and a
//   one-wait-state target are stepped from the stimulus process; a monitor
//   pops the expected grant order and checks fields, ack routing and beats.
module tb_wb_tag_arbiter_rr;

   localparam int unsigned NI = 4;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned TW = 4;
   localparam int unsigned SW = DW / 8;

   logic                i_clock = 1'b0;
   logic                reset;
   logic [NI*AW-1:0]    m_adr;
   logic [NI*DW-1:0]    m_dat_w;
   logic [NI*TW-1:0]    m_tgd_w;
   logic [NI*TW-1:0]    m_tga;
   logic [NI*TW-1:0]    m_tgc;
   logic [NI*SW-1:0]    m_sel;
   logic [NI-1:0]       m_we;
   logic [NI-1:0]       m_cyc;
   logic [NI-1:0]       m_stb;
   logic [NI-1:0]       m_ack;
   logic [DW-1:0]       m_dat_r;
   logic [TW-1:0]       m_tgd_r;
   logic [AW-1:0]       t_adr;
   logic [DW-1:0]       t_dat_w;
   logic [TW-1:0]       t_tgd_w;
   logic [TW-1:0]       t_tga;
   logic [TW-1:0]       t_tgc;
   logic [SW-1:0]       t_sel;
   logic                t_we;
   logic                t_cyc;
   logic                t_stb;
   logic                t_ack;
   logic [DW-1:0]       t_dat_r;
   logic [TW-1:0]       t_tgd_r;

   wb_tag_arbiter_rr #(
      .N_INIT(NI), .ADR_WIDTH(AW), .DAT_WIDTH(DW),
      .TGA_WIDTH(TW), .TGD_WIDTH(TW), .TGC_WIDTH(TW)
   ) dut (
      .i_clock(i_clock), .reset(reset),
      .m_adr(m_adr), .m_dat_w(m_dat_w), .m_tgd_w(m_tgd_w), .m_tga(m_tga),
      .m_tgc(m_tgc), .m_sel(m_sel), .m_we(m_we), .m_cyc(m_cyc), .m_stb(m_stb),
      .m_ack(m_ack), .m_dat_r(m_dat_r), .m_tgd_r(m_tgd_r),
      .t_adr(t_adr), .t_dat_w(t_dat_w), .t_tgd_w(t_tgd_w), .t_tga(t_tga),
      .t_tgc(t_tgc), .t_sel(t_sel), .t_we(t_we), .t_cyc(t_cyc), .t_stb(t_stb),
      .t_ack(t_ack), .t_dat_r(t_dat_r), .t_tgd_r(t_tgd_r)
   );

   always #5 i_clock = ~i_clock;

   typedef struct {
      int k;
      int beats;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   logic mon_busy = 1'b0;

   // Initiator model state
   int   reps  [NI];
   int   nbeats[NI];
   int   left  [NI];

   // Values sampled at the falling edge by step()
   logic          s_stb, s_cyc;
   logic [NI-1:0] s_ack;
   logic [AW-1:0] s_adr;
   logic [DW-1:0] s_dat;
   logic [TW-1:0] s_tga;

   function automatic logic [AW-1:0] exp_adr(int k);
      return AW'(32'h100 * (k + 1));
   endfunction
   function automatic logic [DW-1:0] exp_dat(int k);
      return 32'hA5A5A5A5 ^ (32'h01010101 * DW'(k));
   endfunction
   function automatic logic [TW-1:0] exp_tga(int k);
      return TW'(3 + k);
   endfunction
   function automatic logic [TW-1:0] exp_tgc(int k);
      return TW'(8 + k);
   endfunction
   function automatic logic [TW-1:0] exp_tgd(int k);
      return TW'(12 - k);
   endfunction
   function automatic logic [SW-1:0] exp_sel(int k);
      return SW'(15 >> k);
   endfunction

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   function automatic void push_exp(int k, int beats);
      exp_t e;
      e.k     = k;
      e.beats = beats;
      exp_q.push_back(e);
   endfunction

   function automatic void start(int k, int r, int b);
      reps[k]   = r;
      nbeats[k] = b;
   endfunction

   function automatic bit pending();
      bit p = 1'b0;
      for (int k = 0; k < NI; k++) if (reps[k] > 0) p = 1'b1;
      return p;
   endfunction

   // One clock: sample at negedge, then update initiators and target
   task automatic step();
      @(negedge i_clock);
      s_stb = t_stb;
      s_cyc = t_cyc;
      s_ack = m_ack;
      s_adr = t_adr;
      s_dat = t_dat_w;
      s_tga = t_tga;
      @(posedge i_clock);
      #1;
      for (int k = 0; k < NI; k++) begin
         if (!m_cyc[k]) begin
            if (reps[k] > 0) begin
               m_cyc[k] = 1'b1;
               m_stb[k] = 1'b1;
               left[k]  = nbeats[k];
            end
         end else if (s_ack[k]) begin
            left[k]--;
            if (left[k] == 0) begin
               m_cyc[k] = 1'b0;
               m_stb[k] = 1'b0;
               reps[k]--;
            end
         end
      end
      if (s_stb && !t_ack) begin
         t_ack   = 1'b1;
         t_dat_r = $urandom;
         t_tgd_r = TW'($urandom);
      end else begin
         t_ack = 1'b0;
      end
   endtask

   task automatic run_idle(string name, int budget);
      int n = 0;
      while ((pending() || m_cyc != '0 || exp_q.size() != 0 || mon_busy || t_cyc)
             && n < budget) begin
         step();
         n++;
      end
      step();
      chk({name, "_done"}, 64'(n < budget), 64'd1);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   // Monitor: each new bus cycle pops the next expected grant
   initial begin
      exp_t cur;
      int   acks = 0;
      logic prev_cyc = 1'b0;
      cur.k = 0;
      cur.beats = 0;
      forever begin
         @(negedge i_clock);
         if (t_cyc && !prev_cyc) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_grant", {32'd0, t_adr}, 64'd0);
            end else begin
               cur      = exp_q.pop_front();
               mon_busy = 1'b1;
               acks     = 0;
               chk("grant_adr",   64'(t_adr),   64'(exp_adr(cur.k)));
               chk("grant_dat_w", 64'(t_dat_w), 64'(exp_dat(cur.k)));
               chk("grant_tga",   64'(t_tga),   64'(exp_tga(cur.k)));
               chk("grant_tgc",   64'(t_tgc),   64'(exp_tgc(cur.k)));
               chk("grant_tgd_w", 64'(t_tgd_w), 64'(exp_tgd(cur.k)));
               chk("grant_sel",   64'(t_sel),   64'(exp_sel(cur.k)));
               chk("grant_we",    64'(t_we),    64'((cur.k % 2) == 0));
               chk("grant_stb",   64'(t_stb),   64'd1);
            end
         end
         if (t_cyc && t_ack && mon_busy) begin
            acks++;
            chk("ack_route", 64'(m_ack),   64'(1 << cur.k));
            chk("rdata",     64'(m_dat_r), 64'(t_dat_r));
            chk("rtag",      64'(m_tgd_r), 64'(t_tgd_r));
         end
         if (!t_cyc && t_ack) chk("idle_ack", 64'(m_ack), 64'd0);
         if (!t_cyc && prev_cyc && mon_busy) begin
            chk("beats", 64'(acks), 64'(cur.beats));
            mon_busy = 1'b0;
         end
         prev_cyc = t_cyc;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      reset   = 1'b1;
      m_cyc   = '0;
      m_stb   = '0;
      t_ack   = 1'b0;
      t_dat_r = '0;
      t_tgd_r = '0;
      for (int k = 0; k < NI; k++) begin
         m_adr  [k*AW +: AW] = exp_adr(k);
         m_dat_w[k*DW +: DW] = exp_dat(k);
         m_tga  [k*TW +: TW] = exp_tga(k);
         m_tgc  [k*TW +: TW] = exp_tgc(k);
         m_tgd_w[k*TW +: TW] = exp_tgd(k);
         m_sel  [k*SW +: SW] = exp_sel(k);
         m_we[k]             = ((k % 2) == 0);
         reps[k] = 0;
         nbeats[k] = 1;
         left[k] = 0;
      end
      #13;
      chk("reset_t_cyc", 64'(t_cyc), 64'd0);
      chk("reset_t_stb", 64'(t_stb), 64'd0);
      chk("reset_m_ack", 64'(m_ack), 64'd0);
      step();
      reset = 1'b0;
      step();

      // Single write from m0: one arbitration cycle, then the request
      push_exp(0, 1);
      start(0, 1, 1);
      step();
      step();
      chk("t1_arb_cycle_stb", 64'(s_stb), 64'd0);
      step();
      chk("t1_stb",  64'(s_stb), 64'd1);
      chk("t1_adr",  64'(s_adr), 64'h100);
      chk("t1_dat",  64'(s_dat), 64'hA5A5A5A5);
      chk("t1_tga",  64'(s_tga), 64'd3);
      step();
      chk("t1_ack",  64'(s_ack), 64'b0001);
      step();
      chk("t1_cyc_drop", 64'(s_cyc), 64'd0);
      run_idle("t1", 50);

      // Target ack while idle must not reach any initiator
      t_ack = 1'b1;
      step();
      chk("idle_ack_direct", 64'(s_ack), 64'd0);

      // m0 and m1 together right after reset
      do_reset();
`ifdef WB_TAG_ARB_FIXED_PRIO_EN
      push_exp(0, 1); push_exp(0, 1); push_exp(1, 1);
`else
      push_exp(0, 1); push_exp(1, 1); push_exp(0, 1);
`endif
      start(0, 2, 1);
      start(1, 1, 1);
      run_idle("t2", 100);

      // All four continuously requesting
      do_reset();
`ifdef WB_TAG_ARB_FIXED_PRIO_EN
      push_exp(0, 1); push_exp(0, 1); push_exp(1, 1); push_exp(2, 1); push_exp(3, 1);
`else
      push_exp(0, 1); push_exp(1, 1); push_exp(2, 1); push_exp(3, 1); push_exp(0, 1);
`endif
      start(0, 2, 1);
      start(1, 1, 1);
      start(2, 1, 1);
      start(3, 1, 1);
      run_idle("t3", 200);

      // m1 three-beat burst holds the grant while m0 waits
      push_exp(1, 3);
      push_exp(0, 1);
      start(1, 1, 3);
      step();
      start(0, 1, 1);
      run_idle("t4", 100);

      // Reset pulsed in BUSY while the target acks
      do_reset();
      push_exp(0, 0);
      start(0, 1, 2);
      begin
         int n = 0;
         while (!(t_ack && t_cyc) && n < 20) begin
            step();
            n++;
         end
         chk("t5_reached_ack", 64'(n < 20), 64'd1);
      end
      #2;
      reset = 1'b1;
      #1;
      chk("t5_rst_m_ack", 64'(m_ack), 64'd0);
      chk("t5_rst_t_cyc", 64'(t_cyc), 64'd0);
      chk("t5_rst_t_stb", 64'(t_stb), 64'd0);
      m_cyc[0] = 1'b0;
      m_stb[0] = 1'b0;
      reps[0]  = 0;
      step();
      step();
      reset = 1'b0;
      push_exp(0, 1);
      push_exp(1, 1);
      start(0, 1, 1);
      start(1, 1, 1);
      run_idle("t5", 100);

      // m0 and m2 continuously requesting
      do_reset();
`ifdef WB_TAG_ARB_FIXED_PRIO_EN
      push_exp(0, 1); push_exp(0, 1); push_exp(0, 1); push_exp(2, 1); push_exp(2, 1);
`else
      push_exp(0, 1); push_exp(2, 1); push_exp(0, 1); push_exp(2, 1); push_exp(0, 1);
`endif
      start(0, 3, 1);
      start(2, 2, 1);
      run_idle("t6", 200);

      chk("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
